bullet_scheduler: RTL and testbench

BULLET_SCHEDULER -- requirements
Module: bullet_scheduler

---
 rtl/bullet_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_bullet_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_scheduler.sv
// Bullet scheduler: four bullet slots, round-robin fire arbitration between
// two tanks, per-frame movement sweep and a registered pixel/sprite lookup.
//
// Handshake: fire_req[i] is a level held by tank i until it sees fire_ack[i].
// A grant is decided combinationally in IDLE and fire_ack[i] pulses high for
// exactly the next cycle. While fire_ack[i] is high, request i is not eligible,
// so a request still held during its ack cycle is never granted twice.
module bullet_scheduler #(
  parameter int SPEED = 4,
  parameter int SPR   = 8
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic [1:0]  fire_req,
  input  logic [19:0] fire_x,
  input  logic [19:0] fire_y,
  input  logic [3:0]  fire_dir,
  output logic [1:0]  fire_ack,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic        bullet_on,
  output logic [5:0]  rom_address,
  output logic [3:0]  active_mask,
  output logic        dbg_update,
  output logic [1:0]  dbg_index,
  output logic        dbg_rr
);

  typedef enum logic {IDLE = 1'b0, UPDATE = 1'b1} state_t;

  localparam logic signed [10:0] STEP  = 11'(SPEED);
  localparam logic [9:0]         SPR_W = 10'(SPR);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        rr_q;
  logic [3:0]  valid_q;
  logic [9:0]  x_q [4];
  logic [9:0]  y_q [4];
  logic [1:0]  dir_q [4];

  // arbitration signals
  logic        any_free;
  logic [1:0]  free_idx;
  logic [1:0]  oob;
  logic [1:0]  elig;
  logic        grant;
  logic        sel;
  logic        sel_oob;
  logic [9:0]  sel_x, sel_y;
  logic [1:0]  sel_dir;

  // movement signals
  logic signed [10:0] cx, cy, nx, ny;
  logic               gone;

  // pixel lookup signals
  logic [9:0]  dx, dy;
  logic        hit;
  logic [5:0]  hit_rom;

  // Sprite orientation: sprite is stored pointing up, other directions rotate.
  function automatic logic [5:0] rom_of(input logic [1:0] d,
                                        input logic [2:0] dx3,
                                        input logic [2:0] dy3);
    case (d)
      2'b00:   rom_of = {dy3, dx3};
      2'b10:   rom_of = {~dy3, dx3};
      2'b01:   rom_of = {dx3, ~dy3};
      default: rom_of = {~dx3, dy3};
    endcase
  endfunction

  // FSM state register
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // FSM next state: one slot per UPDATE cycle, frame_start ignored while busy
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = UPDATE;
          idx_d   = 2'd0;
        end
      end
      default: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = IDLE;
          idx_d   = 2'd0;
        end
      end
    endcase
  end

  // Fire arbitration: lowest free slot, round-robin tie break, IDLE only
  always_comb begin
    any_free = 1'b0;
    free_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!valid_q[i]) begin
        any_free = 1'b1;
        free_idx = 2'(i);
      end
    end
    oob[0]  = (fire_x[9:0] > 10'd632) || (fire_y[9:0] > 10'd472);
    oob[1]  = (fire_x[19:10] > 10'd632) || (fire_y[19:10] > 10'd472);
    // off-screen requests are acked without needing a slot
    elig    = {2{state_q == IDLE}} & fire_req & ~fire_ack & ({2{any_free}} | oob);
    grant   = |elig;
    sel     = (&elig) ? rr_q : elig[1];
    sel_oob = sel ? oob[1] : oob[0];
    sel_x   = sel ? fire_x[19:10] : fire_x[9:0];
    sel_y   = sel ? fire_y[19:10] : fire_y[9:0];
    sel_dir = sel ? fire_dir[3:2] : fire_dir[1:0];
  end

  // Movement of the slot currently indexed by the UPDATE sweep
  always_comb begin
    cx = $signed({1'b0, x_q[idx_q]});
    cy = $signed({1'b0, y_q[idx_q]});
    nx = cx;
    ny = cy;
    case (dir_q[idx_q])
      2'b00:   ny = cy - STEP;
      2'b01:   nx = cx + STEP;
      2'b10:   ny = cy + STEP;
      default: nx = cx - STEP;
    endcase
    gone = (nx < 11'sd0) || (nx > 11'sd632) || (ny < 11'sd0) || (ny > 11'sd472);
  end

  // Slot storage, ack pulse and round-robin pointer
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= 4'b0000;
      rr_q     <= 1'b0;
      fire_ack <= 2'b00;
      for (int i = 0; i < 4; i++) begin
        x_q[i]   <= 10'd0;
        y_q[i]   <= 10'd0;
        dir_q[i] <= 2'd0;
      end
    end else begin
      fire_ack <= 2'b00;
      if (grant) begin
        fire_ack[sel] <= 1'b1;
        rr_q          <= ~sel;
        if (!sel_oob) begin
          valid_q[free_idx] <= 1'b1;
          x_q[free_idx]     <= sel_x;
          y_q[free_idx]     <= sel_y;
          dir_q[free_idx]   <= sel_dir;
        end
      end
      if (state_q == UPDATE && valid_q[idx_q]) begin
        if (gone) begin
          valid_q[idx_q] <= 1'b0;
        end else begin
          x_q[idx_q] <= nx[9:0];
          y_q[idx_q] <= ny[9:0];
        end
      end
    end
  end

  // Pixel hit test: unsigned wrap makes DrawX < x fall outside 0..7
  always_comb begin
    hit     = 1'b0;
    hit_rom = 6'd0;
    dx      = 10'd0;
    dy      = 10'd0;
    for (int i = 3; i >= 0; i--) begin
      dx = DrawX - x_q[i];
      dy = DrawY - y_q[i];
      if (valid_q[i] && (dx < SPR_W) && (dy < SPR_W)) begin
        hit     = 1'b1;
        hit_rom = rom_of(dir_q[i], dx[2:0], dy[2:0]);
      end
    end
  end

  // Registered pixel outputs, one cycle behind DrawX/DrawY
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      bullet_on   <= 1'b0;
      rom_address <= 6'd0;
    end else begin
      bullet_on   <= hit;
      rom_address <= hit_rom;
    end
  end

  assign active_mask = valid_q;
  assign dbg_update  = (state_q == UPDATE);
  assign dbg_index   = idx_q;
  assign dbg_rr      = rr_q;

endmodule

// File: tb/tb_bullet_scheduler.sv
// Testbench for bullet_scheduler: directed scenarios, ack/pixel scoreboard.
module tb_bullet_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_start;
  logic [1:0]  fire_req;
  logic [19:0] fire_x, fire_y;
  logic [3:0]  fire_dir;
  logic [1:0]  fire_ack;
  logic [9:0]  DrawX, DrawY;
  logic        bullet_on;
  logic [5:0]  rom_address;
  logic [3:0]  active_mask;
  logic        dbg_update;
  logic [1:0]  dbg_index;
  logic        dbg_rr;

  logic        probe_v = 1'b0;
  logic        probe_d = 1'b0;

  logic [5:0]  exp_q[$];   // {fire_ack, active_mask} at each ack pulse
  logic [6:0]  pix_q[$];   // {bullet_on, rom_address} for each probe

  int errors = 0;
  int checks = 0;

  // clock
  always #5 clk = ~clk;

  // probe strobe delayed to line up with the registered pixel outputs
  always @(posedge clk) probe_d <= probe_v;

  bullet_scheduler dut (
    .vga_clk     (clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .fire_req    (fire_req),
    .fire_x      (fire_x),
    .fire_y      (fire_y),
    .fire_dir    (fire_dir),
    .fire_ack    (fire_ack),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .bullet_on   (bullet_on),
    .rom_address (rom_address),
    .active_mask (active_mask),
    .dbg_update  (dbg_update),
    .dbg_index   (dbg_index),
    .dbg_rr      (dbg_rr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_tank(input int t, input logic [9:0] x, input logic [9:0] y,
                          input logic [1:0] d);
    fire_x[t*10 +: 10] = x;
    fire_y[t*10 +: 10] = y;
    fire_dir[t*2 +: 2] = d;
  endtask

  task automatic expect_ack(input logic [1:0] ack, input logic [3:0] mask);
    exp_q.push_back({ack, mask});
  endtask

  // Each request is dropped one cycle after its ack, so it is still held
  // during the ack cycle itself.
  task automatic wait_acks(input int max_cyc);
    int n;
    logic [1:0] a;
    n = 0;
    while (fire_req != 2'b00 && n < max_cyc) begin
      @(negedge clk);
      a = fire_ack;
      tick();
      fire_req = fire_req & ~a;
      n++;
    end
    checks++;
    if (fire_req != 2'b00) begin
      errors++;
      $display("FAIL ack_timeout: got req=%b still pending expected all acked", fire_req);
      fire_req = 2'b00;
    end
  endtask

  task automatic probe(input logic [9:0] px, input logic [9:0] py,
                       input logic on, input logic [5:0] rom);
    DrawX = px;
    DrawY = py;
    probe_v = 1'b1;
    pix_q.push_back({on, rom});
    tick();
    probe_v = 1'b0;
    DrawX = 10'd1023;
    DrawY = 10'd1023;
    tick();
  endtask

  task automatic fire0(input logic [9:0] x, input logic [9:0] y, input logic [1:0] d,
                       input logic [3:0] mask);
    set_tank(0, x, y, d);
    expect_ack(2'b01, mask);
    fire_req = 2'b01;
    wait_acks(10);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    fire_req = 2'b00;
    frame_start = 1'b0;
    DrawX = 10'd1023;
    DrawY = 10'd1023;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic run_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    reset_n = 1'b0;
    frame_start = 1'b0;
    fire_req = 2'b00;
    fire_x = '0;
    fire_y = '0;
    fire_dir = '0;
    DrawX = 10'd1023;
    DrawY = 10'd1023;
    fork
      // monitor: pops the scoreboard whenever the DUT presents an ack or probe result
      forever begin
        @(negedge clk);
        if (reset_n && fire_ack != 2'b00) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ack: got ack=%b mask=%b expected none", fire_ack, active_mask);
          end else begin
            logic [5:0] e;
            e = exp_q.pop_front();
            if ({fire_ack, active_mask} !== e) begin
              errors++;
              $display("FAIL ack: got ack=%b mask=%b expected ack=%b mask=%b",
                       fire_ack, active_mask, e[5:4], e[3:0]);
            end
          end
        end
        if (probe_d) begin
          checks++;
          if (pix_q.size() == 0) begin
            errors++;
            $display("FAIL probe_underflow: got on=%b rom=%0d expected nothing", bullet_on, rom_address);
          end else begin
            logic [6:0] p;
            p = pix_q.pop_front();
            if ({bullet_on, rom_address} !== p) begin
              errors++;
              $display("FAIL pixel: got on=%b rom=%0d expected on=%b rom=%0d",
                       bullet_on, rom_address, p[6], p[5:0]);
            end
          end
        end
      end
      begin
        #500000;
        errors++;
        checks++;
        $display("FAIL global_timeout: got no completion expected finish");
      end
      begin
        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mask", active_mask, 4'b0000);
        check("rst_ack", fire_ack, 2'b00);
        check("rst_on", bullet_on, 1'b0);
        check("rst_rom", rom_address, 6'd0);
        check("rst_update", dbg_update, 1'b0);
        check("rst_rr", dbg_rr, 1'b0);

        // single fire, one frame of movement to the right
        do_reset();
        fire0(10'd100, 10'd200, 2'b01, 4'b0001);
        @(negedge clk);
        check("a_mask", active_mask, 4'b0001);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        @(negedge clk);
        check("a_update", dbg_update, 1'b1);
        repeat (4) tick();
        @(negedge clk);
        check("a_idle", dbg_update, 1'b0);
        probe(10'd104, 10'd200, 1'b1, 6'd7);   // right: r=dx=0, c=7-dy=7
        probe(10'd103, 10'd200, 1'b0, 6'd0);
        probe(10'd111, 10'd207, 1'b1, 6'd56);  // r=7, c=0

        // simultaneous requests: tank0 first (rr=0), tank1 one cycle later
        do_reset();
        set_tank(0, 10'd10, 10'd10, 2'b00);
        set_tank(1, 10'd50, 10'd50, 2'b00);
        expect_ack(2'b01, 4'b0001);
        expect_ack(2'b10, 4'b0011);
        fire_req = 2'b11;
        tick();
        @(negedge clk);
        check("b_rr1", dbg_rr, 1'b1);
        tick();
        fire_req = 2'b10;
        @(negedge clk);
        check("b_rr0", dbg_rr, 1'b0);
        tick();
        fire_req = 2'b00;
        repeat (2) tick();
        probe(10'd53, 10'd55, 1'b1, 6'd43);
        probe(10'd10, 10'd10, 1'b1, 6'd0);

        // full table stalls; slot2 exits upward during UPDATE, then tank1 fills it
        do_reset();
        fire0(10'd100, 10'd100, 2'b01, 4'b0001);
        fire0(10'd100, 10'd150, 2'b01, 4'b0011);
        set_tank(1, 10'd300, 10'd2, 2'b00);
        set_tank(0, 10'd100, 10'd250, 2'b01);
        expect_ack(2'b10, 4'b0111);   // rr=1 so tank1 wins the tie
        expect_ack(2'b01, 4'b1111);
        fire_req = 2'b11;
        wait_acks(10);
        @(negedge clk);
        check("c_rr", dbg_rr, 1'b1);
        set_tank(1, 10'd200, 10'd200, 2'b10);
        fire_req = 2'b10;
        repeat (5) tick();
        @(negedge clk);
        check("c_full_mask", active_mask, 4'b1111);
        expect_ack(2'b10, 4'b1111);
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        wait_acks(20);
        probe(10'd200, 10'd200, 1'b1, 6'd56);  // down: r=7-dy=7, c=0
        probe(10'd104, 10'd100, 1'b1, 6'd7);

        // off-screen requests are acked without a slot; sprite orientation
        do_reset();
        fire0(10'd300, 10'd473, 2'b00, 4'b0000);
        fire0(10'd633, 10'd100, 2'b00, 4'b0000);
        fire0(10'd300, 10'd300, 2'b00, 4'b0001);
        probe(10'd303, 10'd305, 1'b1, 6'd43);  // up: r=5, c=3
        probe(10'd308, 10'd305, 1'b0, 6'd0);   // dx=8 is outside
        probe(10'd307, 10'd307, 1'b1, 6'd63);
        do_reset();
        fire0(10'd300, 10'd300, 2'b11, 4'b0001);
        probe(10'd303, 10'd305, 1'b1, 6'd37);  // left: r=7-dx=4, c=dy=5

        // right-edge exit at index 0, frame_start during UPDATE ignored
        do_reset();
        fire0(10'd630, 10'd100, 2'b01, 4'b0001);
        fire0(10'd628, 10'd200, 2'b01, 4'b0011);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        @(negedge clk);
        check("f_update", dbg_update, 1'b1);
        check("f_idx0", dbg_index, 2'd0);
        tick();
        @(negedge clk);
        check("f_mask", active_mask, 4'b0010);
        check("f_idx1", dbg_index, 2'd1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        @(negedge clk);
        check("f_idx2", dbg_index, 2'd2);
        repeat (2) tick();
        @(negedge clk);
        check("f_idle", dbg_update, 1'b0);
        probe(10'd632, 10'd200, 1'b1, 6'd7);   // 628+4 = 632 stays live

        // asynchronous reset during UPDATE index 2
        do_reset();
        fire0(10'd100, 10'd100, 2'b00, 4'b0001);
        fire0(10'd200, 10'd100, 2'b00, 4'b0011);
        DrawX = 10'd100;
        DrawY = 10'd100;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("g_idx2", dbg_index, 2'd2);
        check("g_on", bullet_on, 1'b1);
        check("g_rom", rom_address, 6'd32);   // slot0 moved to y=96: dy=4
        #2;
        reset_n = 1'b0;
        #1;
        check("g_mask", active_mask, 4'b0000);
        check("g_on_rst", bullet_on, 1'b0);
        check("g_rom_rst", rom_address, 6'd0);
        check("g_ack_rst", fire_ack, 2'b00);
        check("g_state_rst", dbg_update, 1'b0);
        check("g_idx_rst", dbg_index, 2'd0);
        DrawX = 10'd1023;
        DrawY = 10'd1023;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        @(negedge clk);
        check("g_first_frame", dbg_update, 1'b1);
        repeat (6) tick();

        check("exp_q_empty", 16'(exp_q.size()), 16'd0);
        check("pix_q_empty", 16'(pix_q.size()), 16'd0);
      end
    join_any
    disable fork;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
